// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard scoreboard.
// - FWD_RF : fwd_sel code meaning "take the operand from the register file"
// - tag_t  : one tracked pipeline entry. Fields are sized for the largest
//            supported configuration (TAG_AW address bits, TAG_NSRC sources).
//            Narrower instances zero-extend their addresses into it, so
//            equality compares are unaffected.
package hazard_pkg;

  localparam int TAG_AW   = 8;
  localparam int TAG_NSRC = 4;
  localparam int FWD_RF   = 0;

  typedef struct packed {
    logic                             valid;
    logic                             reg_write;
    logic                             is_load;
    logic [TAG_AW-1:0]                dest;
    logic [TAG_NSRC-1:0][TAG_AW-1:0]  src;
    logic [TAG_NSRC-1:0]              src_used;
  } tag_t;

  localparam tag_t TAG_BUBBLE = '0;

endpackage

// File: rtl/hazard_match.sv
// One producer/consumer dependency comparator.
// Ports:
//   prod_valid_i, prod_reg_write_i, prod_dest_i : older instruction (producer)
//   cons_valid_i, cons_used_i, cons_src_i       : younger instruction's source
//   match_o                                     : consumer reads producer's result
module hazard_match
  import hazard_pkg::*;
#(
  parameter int R0_ZERO = 1
) (
  input  logic              prod_valid_i,
  input  logic              prod_reg_write_i,
  input  logic [TAG_AW-1:0] prod_dest_i,
  input  logic              cons_valid_i,
  input  logic              cons_used_i,
  input  logic [TAG_AW-1:0] cons_src_i,
  output logic              match_o
);

  logic addr_ok;

  // r0 is hardwired zero when R0_ZERO is set, so it never creates a dependency
  assign addr_ok = (R0_ZERO == 0) || (cons_src_i != '0);

  assign match_o = prod_valid_i & prod_reg_write_i & cons_valid_i & cons_used_i &
                   (prod_dest_i == cons_src_i) & addr_ok;

endmodule

// File: rtl/hazard_scoreboard.sv
// In-order pipeline hazard scoreboard: tracks DEPTH stages after ID, detects
// load-use hazards (stall), selects forwarding sources for the EX stage and
// inserts bubbles after a branch/jump flush.
// Ports:
//   clk, rst                 : clock, async active-high reset
//   id_valid/src/src_used    : ID-stage instruction and its source operands
//   id_dest/reg_write/is_load: ID-stage destination info
//   flush                    : redirect pulse
//   stall                    : hold PC and IF/ID (combinational)
//   fwd_sel                  : per-source EX select, 0 = register file,
//                              k = value from stage k+1
//   ex_valid                 : stage 1 holds a real instruction
//   flush_active             : flush bubbles are being inserted
//   stall_cnt                : saturating count of stall cycles
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int ADDR_W       = 3,
  parameter int NUM_SRC      = 2,
  parameter int DEPTH        = 3,
  parameter int FLUSH_CYCLES = 2,
  parameter int R0_ZERO      = 1,
  localparam int SEL_W       = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [NUM_SRC*ADDR_W-1:0] id_src,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic [ADDR_W-1:0]         id_dest,
  input  logic                      id_reg_write,
  input  logic                      id_is_load,
  input  logic                      flush,
  output logic                      stall,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
  output logic                      ex_valid,
  output logic                      flush_active,
  output logic [15:0]               stall_cnt
);

  tag_t                          tag_q [1:DEPTH];
  tag_t                          id_tag;
  tag_t                          tag1_d;
  logic [NUM_SRC-1:0]            ld_hit;
  logic [DEPTH:2][NUM_SRC-1:0]   fwd_hit;
  logic [2:0]                    flush_cnt_q, flush_cnt_d;
  logic [15:0]                   stall_cnt_q, stall_cnt_d;
  logic                          issue;

  // Widen the ID instruction into the shared tag record
  always_comb begin
    id_tag           = TAG_BUBBLE;
    id_tag.valid     = id_valid;
    id_tag.reg_write = id_reg_write;
    id_tag.is_load   = id_is_load;
    id_tag.dest      = TAG_AW'(id_dest);
    for (int s = 0; s < NUM_SRC; s++) begin
      id_tag.src[s]      = TAG_AW'(id_src[s*ADDR_W +: ADDR_W]);
      id_tag.src_used[s] = id_src_used[s];
    end
  end

  genvar gs, gk;
  for (gs = 0; gs < NUM_SRC; gs++) begin : g_src
    // ID source vs. stage 1 (load-use check)
    hazard_match #(.R0_ZERO(R0_ZERO)) u_ld (
      .prod_valid_i     (tag_q[1].valid),
      .prod_reg_write_i (tag_q[1].reg_write),
      .prod_dest_i      (tag_q[1].dest),
      .cons_valid_i     (id_tag.valid),
      .cons_used_i      (id_tag.src_used[gs]),
      .cons_src_i       (id_tag.src[gs]),
      .match_o          (ld_hit[gs])
    );
    // EX source vs. every older tracked stage (forwarding)
    for (gk = 2; gk <= DEPTH; gk++) begin : g_stg
      hazard_match #(.R0_ZERO(R0_ZERO)) u_fwd (
        .prod_valid_i     (tag_q[gk].valid),
        .prod_reg_write_i (tag_q[gk].reg_write),
        .prod_dest_i      (tag_q[gk].dest),
        .cons_valid_i     (tag_q[1].valid),
        .cons_used_i      (tag_q[1].src_used[gs]),
        .cons_src_i       (tag_q[1].src[gs]),
        .match_o          (fwd_hit[gk][gs])
      );
    end
  end

  // A load in EX cannot forward in time; a flush discards ID anyway, so it wins
  assign stall = (|ld_hit) & tag_q[1].is_load & ~flush & ~flush_active;

  // Youngest producer wins: scan oldest to newest so the lowest stage sticks
  always_comb begin
    fwd_sel = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      fwd_sel[s*SEL_W +: SEL_W] = SEL_W'(FWD_RF);
      for (int k = DEPTH; k >= 2; k--) begin
        if (fwd_hit[k][s]) fwd_sel[s*SEL_W +: SEL_W] = SEL_W'(k - 1);
      end
    end
  end

  assign flush_active = (flush_cnt_q != 3'd0);
  assign issue        = id_valid & ~stall & ~flush_active & ~flush;
  assign tag1_d       = issue ? id_tag : TAG_BUBBLE;

  always_comb begin
    flush_cnt_d = flush_cnt_q;
    if (flush)             flush_cnt_d = 3'(FLUSH_CYCLES);
    else if (flush_active) flush_cnt_d = flush_cnt_q - 3'd1;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 1; k <= DEPTH; k++) tag_q[k] <= TAG_BUBBLE;
      flush_cnt_q <= 3'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      tag_q[1] <= tag1_d;
      for (int k = 2; k <= DEPTH; k++) tag_q[k] <= tag_q[k-1];
      flush_cnt_q <= flush_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ex_valid  = tag_q[1].valid;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_reg_write, id_is_load, flush;
  logic [5:0]  id_src_a;
  logic [8:0]  id_src_b;
  logic [1:0]  used_a;
  logic [2:0]  used_b;
  logic [2:0]  id_dest;

  logic        stall_a, exv_a, fa_a;
  logic [3:0]  fwd_a;
  logic [15:0] sc_a;
  logic        stall_b, exv_b, fa_b;
  logic [8:0]  fwd_b;
  logic [15:0] sc_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_scoreboard u_a (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src(id_src_a),
    .id_src_used(used_a), .id_dest(id_dest), .id_reg_write(id_reg_write),
    .id_is_load(id_is_load), .flush(flush), .stall(stall_a), .fwd_sel(fwd_a),
    .ex_valid(exv_a), .flush_active(fa_a), .stall_cnt(sc_a)
  );

  hazard_scoreboard #(.NUM_SRC(3), .DEPTH(5)) u_b (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src(id_src_b),
    .id_src_used(used_b), .id_dest(id_dest), .id_reg_write(id_reg_write),
    .id_is_load(id_is_load), .flush(flush), .stall(stall_b), .fwd_sel(fwd_b),
    .ex_valid(exv_b), .flush_active(fa_b), .stall_cnt(sc_b)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [2:0] s0, input logic [2:0] s1,
                        input logic [2:0] s2, input logic [2:0] u, input logic [2:0] d,
                        input logic w, input logic l);
    id_valid = v; id_src_a = {s1, s0}; id_src_b = {s2, s1, s0};
    used_a = u[1:0]; used_b = u; id_dest = d; id_reg_write = w; id_is_load = l;
  endtask

  task automatic nop();
    set_id(1'b0, 3'd0, 3'd0, 3'd0, 3'b000, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drain();
    nop(); flush = 1'b0;
    repeat (6) tick();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; nop();
    repeat (2) tick();
    chk("rst_stall", stall_a, 0);
    chk("rst_fwd", fwd_a, 0);
    chk("rst_exv", exv_a, 0);
    chk("rst_fa", fa_a, 0);
    chk("rst_sc", sc_a, 0);
    chk("rst_fwd_b", fwd_b, 0);
    rst = 1'b0;
    tick();

    // add r1 then immediate consumer -> forward from stage 2
    set_id(1, 0, 0, 0, 3'b000, 1, 1, 0); #1;
    chk("add_nostall", stall_a, 0);
    tick();
    set_id(1, 1, 0, 0, 3'b001, 4, 1, 0); #1;
    chk("add_use_nostall", stall_a, 0);
    tick();
    nop(); #1;
    chk("fwd1_exv", exv_a, 1);
    chk("fwd1_a", fwd_a[1:0], 1);
    chk("fwd1_b", fwd_b[2:0], 1);
    drain();

    // add r1, gap, consumer -> forward from stage 3
    set_id(1, 0, 0, 0, 3'b000, 1, 1, 0); tick();
    nop(); tick();
    set_id(1, 1, 0, 0, 3'b001, 4, 1, 0); tick();
    nop(); #1;
    chk("fwd2_a", fwd_a[1:0], 2);
    chk("fwd2_b", fwd_b[2:0], 2);
    drain();

    // load r3 then consumer -> single stall cycle
    set_id(1, 0, 0, 0, 3'b000, 3, 1, 1); #1;
    chk("ld_nostall", stall_a, 0);
    tick();
    set_id(1, 3, 0, 0, 3'b001, 5, 1, 0); #1;
    chk("lu_stall_a", stall_a, 1);
    chk("lu_stall_b", stall_b, 1);
    tick();
    chk("lu_bubble_exv", exv_a, 0);
    chk("lu_stall_once", stall_a, 0);
    chk("lu_sc_a", sc_a, 1);
    tick();
    nop(); #1;
    chk("lu_exv", exv_a, 1);
    chk("lu_fwd_a", fwd_a[1:0], 2);
    chk("lu_fwd_b", fwd_b[2:0], 2);
    chk("lu_sc_a2", sc_a, 1);
    chk("lu_sc_b", sc_b, 1);
    drain();

    // two producers of r2 -> youngest (stage 2) wins; unused src0 ignored
    set_id(1, 0, 0, 0, 3'b000, 2, 1, 0); tick();
    set_id(1, 0, 0, 0, 3'b000, 2, 1, 0); tick();
    set_id(1, 2, 2, 0, 3'b010, 6, 1, 0); #1;
    chk("pri_nostall", stall_a, 0);
    tick();
    nop(); #1;
    chk("pri_fwd_a", fwd_a, 4'b0100);
    chk("pri_fwd_b", fwd_b, 9'b000_001_000);
    drain();

    // load to r0 then r0 consumer -> no dependency
    set_id(1, 0, 0, 0, 3'b000, 0, 1, 1); tick();
    set_id(1, 0, 0, 0, 3'b001, 5, 1, 0); #1;
    chk("r0_nostall", stall_a, 0);
    tick();
    nop(); #1;
    chk("r0_exv", exv_a, 1);
    chk("r0_fwd", fwd_a, 0);
    chk("r0_sc", sc_a, 1);
    drain();

    // flush coincident with load-use: flush wins, bubbles inserted
    set_id(1, 0, 0, 0, 3'b000, 3, 1, 1); tick();
    set_id(1, 3, 0, 0, 3'b001, 5, 1, 0); flush = 1'b1; #1;
    chk("fl_stall", stall_a, 0);
    chk("fl_fa0", fa_a, 0);
    tick();
    flush = 1'b0; #1;
    chk("fl_fa1", fa_a, 1);
    chk("fl_exv1", exv_a, 0);
    chk("fl_stall1", stall_a, 0);
    tick();
    chk("fl_fa2", fa_a, 1);
    chk("fl_exv2", exv_a, 0);
    tick();
    chk("fl_fa3", fa_a, 0);
    chk("fl_exv3", exv_a, 0);
    tick();
    nop(); #1;
    chk("fl_exv4", exv_a, 1);
    chk("fl_sc", sc_a, 1);
    chk("fl_fwd_a", fwd_a[1:0], 0);
    chk("fl_fwd_b", fwd_b[2:0], 4);
    drain();

    // deep-pipe forwarding on src2 (DEPTH=5, NUM_SRC=3 instance)
    for (int d = 3; d <= 4; d++) begin
      set_id(1, 0, 0, 0, 3'b000, 6, 1, 0); tick();
      nop();
      repeat (d - 1) tick();
      set_id(1, 0, 0, 6, 3'b100, 7, 0, 0); tick();
      nop(); #1;
      chk($sformatf("deep_b_d%0d", d), fwd_b[8:6], 16'(d));
      chk($sformatf("deep_a_d%0d", d), fwd_a, 0);
      drain();
    end

    // async reset in the middle of a flush
    set_id(1, 0, 0, 0, 3'b000, 1, 1, 0); tick();
    set_id(1, 1, 0, 0, 3'b001, 4, 1, 0); tick();
    nop(); flush = 1'b1; #1;
    chk("pre_rst_fwd", fwd_a[1:0], 1);
    tick();
    flush = 1'b0; #1;
    chk("pre_rst_fa", fa_a, 1);
    chk("pre_rst_sc", sc_a, 1);
    #2 rst = 1'b1; #1;
    chk("mid_rst_fa", fa_a, 0);
    chk("mid_rst_fa_b", fa_b, 0);
    chk("mid_rst_exv", exv_a, 0);
    chk("mid_rst_stall", stall_a, 0);
    chk("mid_rst_fwd", fwd_a, 0);
    chk("mid_rst_sc", sc_a, 0);
    chk("mid_rst_sc_b", sc_b, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_fa", fa_a, 0);
    chk("post_rst_exv", exv_a, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
